// File: rtl/bp_pkg.sv
// rtl/bp_pkg.sv - shared encodings and default sizing for the branch predictor
package bp_pkg;

  localparam int BP_ENTRIES = 16;
  localparam int BP_IDX_W   = $clog2(BP_ENTRIES);

  typedef enum logic [1:0] {
    SNT = 2'b00,
    WNT = 2'b01,
    WT  = 2'b10,
    ST  = 2'b11
  } ctr_e;

endpackage

// File: rtl/branch_predictor_if.sv
// rtl/branch_predictor_if.sv - fetch lookup, EX resolution and statistics signals
interface branch_predictor_if;

  logic [31:0] if_pc;
  logic        predict_taken;
  logic [31:0] predict_target;
  logic        ex_branch;
  logic [31:0] ex_pc;
  logic        ex_taken;
  logic [31:0] ex_target;
  logic        ex_prediction;
  logic        mispredict;
  logic [31:0] redirect_pc;
  logic [15:0] branch_count;
  logic [15:0] miss_count;

  modport master (
    output if_pc, ex_branch, ex_pc, ex_taken, ex_target, ex_prediction,
    input  predict_taken, predict_target, mispredict, redirect_pc,
           branch_count, miss_count
  );

  modport slave (
    input  if_pc, ex_branch, ex_pc, ex_taken, ex_target, ex_prediction,
    output predict_taken, predict_target, mispredict, redirect_pc,
           branch_count, miss_count
  );

endinterface

// File: rtl/sat_counter2.sv
// rtl/sat_counter2.sv - next state of a 2-bit saturating branch history counter
module sat_counter2
  import bp_pkg::*;
(
  input  ctr_e cur,
  input  logic taken,
  output ctr_e nxt
);

  always_comb begin
    nxt = cur;
    case (cur)
      SNT:     nxt = taken ? WNT : SNT;
      WNT:     nxt = taken ? WT  : SNT;
      WT:      nxt = taken ? ST  : WNT;
      ST:      nxt = taken ? ST  : WT;
      default: nxt = cur;
    endcase
  end

endmodule

// File: rtl/branch_predictor.sv
// rtl/branch_predictor.sv - direct-mapped BTB with 2-bit counters, combinational lookup
module branch_predictor
  import bp_pkg::*;
#(
  parameter int ENTRIES = BP_ENTRIES
) (
  input  logic               clk,
  input  logic               rst,
  branch_predictor_if.slave  bus
);

  localparam int IDX_W = $clog2(ENTRIES);
  localparam int TAG_W = 30 - IDX_W;

  logic              valid_q  [ENTRIES];
  logic [TAG_W-1:0]  tag_q    [ENTRIES];
  logic [31:0]       target_q [ENTRIES];
  ctr_e              ctr_q    [ENTRIES];

  logic [IDX_W-1:0]  f_idx, e_idx;
  logic [TAG_W-1:0]  f_tag, e_tag;
  logic              f_hit, e_hit;
  ctr_e              f_ctr, e_ctr, e_ctr_nxt;
  logic [15:0]       branch_cnt_q, miss_cnt_q;
  logic              unused_pc_bits;

  assign f_idx = bus.if_pc[IDX_W+1:2];
  assign f_tag = bus.if_pc[31:IDX_W+2];
  assign e_idx = bus.ex_pc[IDX_W+1:2];
  assign e_tag = bus.ex_pc[31:IDX_W+2];
  assign unused_pc_bits = ^{bus.if_pc[1:0], bus.ex_pc[1:0]};

  // Lookup reads registered state only, so a same-index update lands next cycle
  assign f_ctr = ctr_q[f_idx];
  assign f_hit = valid_q[f_idx] && (tag_q[f_idx] == f_tag);
  assign bus.predict_taken  = f_hit && f_ctr[1];
  assign bus.predict_target = f_hit ? target_q[f_idx] : 32'd0;

  assign e_ctr = ctr_q[e_idx];
  assign e_hit = valid_q[e_idx] && (tag_q[e_idx] == e_tag);

  assign bus.mispredict  = bus.ex_branch && (bus.ex_prediction != bus.ex_taken);
  assign bus.redirect_pc = !bus.mispredict ? 32'd0 :
                           bus.ex_taken    ? bus.ex_target : bus.ex_pc + 32'd4;

  sat_counter2 u_ctr (
    .cur   (e_ctr),
    .taken (bus.ex_taken),
    .nxt   (e_ctr_nxt)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < ENTRIES; i++) begin
        valid_q[i]  <= 1'b0;
        tag_q[i]    <= '0;
        target_q[i] <= 32'd0;
        ctr_q[i]    <= WNT;
      end
    end else if (bus.ex_branch) begin
      if (e_hit) begin
        ctr_q[e_idx] <= e_ctr_nxt;
        if (bus.ex_taken) target_q[e_idx] <= bus.ex_target;
      end else if (bus.ex_taken) begin
        // Taken miss evicts whatever aliased into this slot
        valid_q[e_idx]  <= 1'b1;
        tag_q[e_idx]    <= e_tag;
        target_q[e_idx] <= bus.ex_target;
        ctr_q[e_idx]    <= WT;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      branch_cnt_q <= 16'd0;
      miss_cnt_q   <= 16'd0;
    end else begin
      if (bus.ex_branch && branch_cnt_q != 16'hFFFF) branch_cnt_q <= branch_cnt_q + 16'd1;
      if (bus.mispredict && miss_cnt_q != 16'hFFFF)  miss_cnt_q   <= miss_cnt_q + 16'd1;
    end
  end

  assign bus.branch_count = branch_cnt_q;
  assign bus.miss_count   = miss_cnt_q;

endmodule

// File: tb/tb_branch_predictor.sv
// tb/tb_branch_predictor.sv - directed checks of lookup, update, aliasing and reset
module tb_branch_predictor;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_vec  = 0;
  int   n_miss = 0;

  branch_predictor_if bp ();

  branch_predictor #(.ENTRIES(16)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bp)
  );

  always #5 clk = ~clk;

  task automatic idle();
    bp.ex_branch     = 1'b0;
    bp.ex_pc         = 32'd0;
    bp.ex_taken      = 1'b0;
    bp.ex_target     = 32'd0;
    bp.ex_prediction = 1'b0;
  endtask

  task automatic resolve(input logic [31:0] pc, input logic tk,
                         input logic [31:0] tgt, input logic pred);
    bp.ex_branch     = 1'b1;
    bp.ex_pc         = pc;
    bp.ex_taken      = tk;
    bp.ex_target     = tgt;
    bp.ex_prediction = pred;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    idle();
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    bp.if_pc = 32'h0040_0010;
    #1;
    n_vec++; if (bp.predict_taken !== 1'b0) begin n_miss++; $display("FAIL reset_taken got %0b exp 0", bp.predict_taken); end
    n_vec++; if (bp.predict_target !== 32'd0) begin n_miss++; $display("FAIL reset_target got %h exp 0", bp.predict_target); end
    n_vec++; if (bp.branch_count !== 16'd0) begin n_miss++; $display("FAIL reset_bcount got %0d exp 0", bp.branch_count); end
    n_vec++; if (bp.miss_count !== 16'd0) begin n_miss++; $display("FAIL reset_mcount got %0d exp 0", bp.miss_count); end
  endtask

  task automatic test_allocate();
    @(negedge clk);
    bp.if_pc = 32'h0040_0010;
    resolve(32'h0040_0010, 1'b1, 32'h0040_0100, 1'b0);
    #1;
    n_vec++; if (bp.mispredict !== 1'b1) begin n_miss++; $display("FAIL alloc_mispredict got %0b exp 1", bp.mispredict); end
    n_vec++; if (bp.redirect_pc !== 32'h0040_0100) begin n_miss++; $display("FAIL alloc_redirect got %h exp 00400100", bp.redirect_pc); end
    n_vec++; if (bp.predict_taken !== 1'b0) begin n_miss++; $display("FAIL alloc_same_cycle_old got %0b exp 0", bp.predict_taken); end
    @(negedge clk);
    idle();
    #1;
    n_vec++; if (bp.predict_taken !== 1'b1) begin n_miss++; $display("FAIL alloc_taken got %0b exp 1", bp.predict_taken); end
    n_vec++; if (bp.predict_target !== 32'h0040_0100) begin n_miss++; $display("FAIL alloc_target got %h exp 00400100", bp.predict_target); end
    n_vec++; if (bp.branch_count !== 16'd1) begin n_miss++; $display("FAIL alloc_bcount got %0d exp 1", bp.branch_count); end
    n_vec++; if (bp.miss_count !== 16'd1) begin n_miss++; $display("FAIL alloc_mcount got %0d exp 1", bp.miss_count); end
  endtask

  // Counter 10 -> 01 -> 00 -> 00, then taken twice: 01 (still not taken), 10
  task automatic test_saturate_down();
    logic exp_pt [5] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
    logic tk     [5] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1};
    logic pred   [5] = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0};
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      resolve(32'h0040_0010, tk[i], 32'h0040_0100, pred[i]);
      #1;
      if (i == 0) begin
        n_vec++; if (bp.redirect_pc !== 32'h0040_0014) begin n_miss++; $display("FAIL nt_redirect got %h exp 00400014", bp.redirect_pc); end
      end
      n_vec++; if (bp.mispredict !== (pred[i] != tk[i])) begin n_miss++; $display("FAIL sat_dn_mispredict[%0d] got %0b exp %0b", i, bp.mispredict, pred[i] != tk[i]); end
      @(negedge clk);
      idle();
      #1;
      n_vec++; if (bp.predict_taken !== exp_pt[i]) begin n_miss++; $display("FAIL sat_dn_taken[%0d] got %0b exp %0b", i, bp.predict_taken, exp_pt[i]); end
    end
    n_vec++; if (bp.branch_count !== 16'd6) begin n_miss++; $display("FAIL sat_dn_bcount got %0d exp 6", bp.branch_count); end
    n_vec++; if (bp.miss_count !== 16'd4) begin n_miss++; $display("FAIL sat_dn_mcount got %0d exp 4", bp.miss_count); end
  endtask

  // From 10: taken -> 11, taken -> 11, not taken -> 10 (still predicts taken)
  task automatic test_saturate_up();
    logic tk [3] = '{1'b1, 1'b1, 1'b0};
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      resolve(32'h0040_0010, tk[i], 32'h0040_0180, 1'b1);
      @(negedge clk);
      idle();
    end
    #1;
    n_vec++; if (bp.predict_taken !== 1'b1) begin n_miss++; $display("FAIL sat_up_taken got %0b exp 1", bp.predict_taken); end
    n_vec++; if (bp.predict_target !== 32'h0040_0180) begin n_miss++; $display("FAIL sat_up_target got %h exp 00400180", bp.predict_target); end
  endtask

  task automatic test_aliasing();
    do_reset();
    @(negedge clk);
    resolve(32'h0040_0010, 1'b1, 32'h0040_0100, 1'b0);
    @(negedge clk);
    idle();
    bp.if_pc = 32'h0040_0050;
    #1;
    n_vec++; if (bp.predict_taken !== 1'b0) begin n_miss++; $display("FAIL alias_lookup got %0b exp 0", bp.predict_taken); end
    n_vec++; if (bp.predict_target !== 32'd0) begin n_miss++; $display("FAIL alias_target got %h exp 0", bp.predict_target); end
    @(negedge clk);
    resolve(32'h0040_0050, 1'b1, 32'h0040_0200, 1'b0);
    @(negedge clk);
    resolve(32'h0040_0090, 1'b0, 32'h0040_0300, 1'b0);
    @(negedge clk);
    idle();
    bp.if_pc = 32'h0040_0053;
    #1;
    n_vec++; if (bp.predict_taken !== 1'b1) begin n_miss++; $display("FAIL alias_new_taken got %0b exp 1", bp.predict_taken); end
    n_vec++; if (bp.predict_target !== 32'h0040_0200) begin n_miss++; $display("FAIL alias_new_target got %h exp 00400200", bp.predict_target); end
    bp.if_pc = 32'h0040_0010;
    #1;
    n_vec++; if (bp.predict_taken !== 1'b0) begin n_miss++; $display("FAIL alias_evicted got %0b exp 0", bp.predict_taken); end
  endtask

  task automatic test_same_cycle();
    @(negedge clk);
    bp.if_pc = 32'h0040_0050;
    resolve(32'h0040_0050, 1'b0, 32'h0040_0200, 1'b1);
    #1;
    n_vec++; if (bp.predict_taken !== 1'b1) begin n_miss++; $display("FAIL same_cycle_old got %0b exp 1", bp.predict_taken); end
    @(negedge clk);
    idle();
    #1;
    n_vec++; if (bp.predict_taken !== 1'b0) begin n_miss++; $display("FAIL same_cycle_new got %0b exp 0", bp.predict_taken); end
  endtask

  task automatic test_async_reset();
    @(negedge clk);
    bp.if_pc = 32'h0040_0010;
    resolve(32'h0040_0010, 1'b1, 32'h0040_0100, 1'b0);
    @(negedge clk);
    resolve(32'h0040_0020, 1'b1, 32'h0000_0123, 1'b0);
    #1;
    n_vec++; if (bp.predict_taken !== 1'b1) begin n_miss++; $display("FAIL pre_reset_taken got %0b exp 1", bp.predict_taken); end
    #1 rst = 1'b1;
    #1;
    n_vec++; if (bp.predict_taken !== 1'b0) begin n_miss++; $display("FAIL async_taken got %0b exp 0", bp.predict_taken); end
    n_vec++; if (bp.predict_target !== 32'd0) begin n_miss++; $display("FAIL async_target got %h exp 0", bp.predict_target); end
    n_vec++; if (bp.branch_count !== 16'd0) begin n_miss++; $display("FAIL async_bcount got %0d exp 0", bp.branch_count); end
    n_vec++; if (bp.mispredict !== 1'b1) begin n_miss++; $display("FAIL async_mispredict got %0b exp 1", bp.mispredict); end
    @(negedge clk);
    rst = 1'b0;
    idle();
    bp.if_pc = 32'h0040_0020;
    #1;
    n_vec++; if (bp.predict_taken !== 1'b0) begin n_miss++; $display("FAIL async_lost_update got %0b exp 0", bp.predict_taken); end
    n_vec++; if (bp.miss_count !== 16'd0) begin n_miss++; $display("FAIL async_mcount got %0d exp 0", bp.miss_count); end
  endtask

  initial begin
    bp.if_pc = 32'd0;
    idle();
    test_reset();
    test_allocate();
    test_saturate_down();
    test_saturate_up();
    test_aliasing();
    test_same_cycle();
    test_async_reset();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule

// File: doc/branch_predictor.md
BRANCH_PREDICTOR -- requirements
Module: branch_predictor

Interface
REQ-001 Parameter: ENTRIES, default 16, number of predictor/BTB entries (power of two); IDX_W = log2(ENTRIES).
REQ-002 clk  input  1  clock; all state updates occur on the rising edge.
REQ-003 rst  input  1  reset, asynchronous, active-high.
REQ-004 if_pc  input  32  fetch-stage PC to predict.
REQ-005 predict_taken  output  1  fetch-stage prediction; this bit travels down the pipeline through the ID/EX register as the prediction bit.
REQ-006 predict_target  output  32  predicted target for if_pc; valid only when predict_taken=1.
REQ-007 ex_branch  input  1  EX stage holds a resolved conditional branch this cycle.
REQ-008 ex_pc  input  32  PC of the resolving branch.
REQ-009 ex_taken  input  1  actual branch outcome.
REQ-010 ex_target  input  32  actual branch target.
REQ-011 ex_prediction  input  1  prediction bit as delivered out of the ID/EX register.
REQ-012 mispredict  output  1  flush request to IF/ID and ID/EX.
REQ-013 redirect_pc  output  32  corrected fetch PC; valid only when mispredict=1.
REQ-014 branch_count  output  16  resolved-branch counter.
REQ-015 miss_count  output  16  misprediction counter.

Function
REQ-016 The table SHALL hold per entry: valid (1), tag (32-2-IDX_W bits = pc[31:IDX_W+2]), target (32) and a 2-bit saturating counter.
REQ-017 Index SHALL be pc[IDX_W+1:2]; pc[1:0] SHALL be ignored.
REQ-018 Lookup SHALL be combinational: predict_taken = valid && tag match && counter[1]; predict_target = stored target.
REQ-019 predict_target SHALL be 0 when there is no hit.
REQ-020 mispredict SHALL be combinational: ex_branch && (ex_prediction != ex_taken); it SHALL be 0 when ex_branch=0.
REQ-021 redirect_pc SHALL be ex_target if ex_taken, else ex_pc+4 (mod 2^32); it SHALL be 0 when mispredict=0.
REQ-022 On ex_branch with a tag hit, the counter SHALL increment if taken or decrement if not taken, saturating at 2'b11 and 2'b00.
REQ-023 On ex_branch with a tag hit and ex_taken=1, the stored target SHALL be overwritten with ex_target.
REQ-024 On ex_branch with a miss and ex_taken=1, the entry SHALL be allocated: valid=1, tag, target and counter=2'b10 (weak taken); any prior occupant is replaced.
REQ-025 On ex_branch with a miss and ex_taken=0, the table SHALL NOT change.
REQ-026 When if_pc and ex_pc hit the same index in one cycle, the lookup SHALL return the pre-update contents; the update takes effect from the next cycle.
REQ-027 Each ex_branch SHALL increment branch_count by 1, saturating at 16'hFFFF.
REQ-028 Each mispredict SHALL increment miss_count by 1, saturating at 16'hFFFF.
REQ-029 All table and counter updates SHALL take one cycle.
REQ-030 The block SHALL never stall; there is no handshake.

Reset
REQ-031 On rst, all valid bits, tags, targets and both statistic counters SHALL clear to 0, and all predictor counters SHALL go to 2'b01 (weak not-taken).
REQ-032 Consequences of REQ-031: during and after reset, predict_taken=0, predict_target=0 and the statistic outputs are 0; mispredict and redirect_pc continue to follow their inputs.
REQ-033 If rst asserts while an update is pending, that update SHALL be discarded.

Structure
REQ-034 A shared package bp_pkg SHALL hold the counter encodings (SNT=00, WNT=01, WT=10, ST=11) and the default ENTRIES/IDX_W constants.
REQ-035 A single sub-module sat_counter2 (2-bit saturating up/down counter with next-state logic) is natural and SHALL be used for the per-entry counter update.

Verification
REQ-036 Reset, then if_pc=0x00400010 -> predict_taken=0, predict_target=0, both counts 0.
REQ-037 ex_branch=1, ex_pc=0x00400010, ex_taken=1, ex_target=0x00400100, ex_prediction=0:
- same cycle: mispredict=1, redirect_pc=0x00400100.
- next cycle, if_pc=0x00400010: predict_taken=1, predict_target=0x00400100, branch_count=1, miss_count=1.
REQ-038 Starting from the state left by REQ-037, three not-taken resolutions of 0x00400010 -> counter 10->01->00->00 (saturates); predict_taken=0 after the first; on the first, redirect_pc=0x00400014.
REQ-039 Aliasing: allocate 0x00400010, then look up 0x00400050 (same index, different tag) -> predict_taken=0; a taken resolution of 0x00400050 replaces the entry, and a subsequent lookup of 0x00400010 returns predict_taken=0.
REQ-040 Same-cycle update and lookup at one index -> the lookup shows the old value in that cycle and the new value in the next.
REQ-041 Assert rst asynchronously mid-cycle with ex_branch=1 -> table cleared immediately, the update is lost, and the counts read 0.
